// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM-style memory port among NUM_MASTERS requesters,
// with in-order read-data return. Define MEM_ARB_PRIORITY0_EN to give master 0 fixed priority.

module mem_arbiter #(
    parameter int  NUM_MASTERS = 16,
    parameter int  ADDR_WIDTH  = 16,
    parameter int  DATA_WIDTH  = 24,
    parameter int  MAX_PENDING = 8,
    localparam int IDW         = $clog2(NUM_MASTERS)
) (
    input  logic                              clk_i,
    input  logic                              srst_i,
    input  logic [NUM_MASTERS-1:0]            m_read_i,
    input  logic [NUM_MASTERS-1:0]            m_write_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_writedata_i,
    output logic [NUM_MASTERS-1:0]            m_waitrequest_o,
    output logic [DATA_WIDTH-1:0]             m_readdata_o,
    output logic [NUM_MASTERS-1:0]            m_readdatavalid_o,
    output logic                              mem_read_o,
    output logic                              mem_write_o,
    output logic [ADDR_WIDTH+IDW-1:0]         mem_address_o,
    output logic [DATA_WIDTH-1:0]             mem_writedata_o,
    input  logic                              mem_waitrequest_i,
    input  logic [DATA_WIDTH-1:0]             mem_readdata_i,
    input  logic                              mem_readdatavalid_i,
    output logic                              err_o
);
    localparam int PW = $clog2(MAX_PENDING);

    typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

    state_t         r_state, w_state_nxt;
    logic [IDW-1:0] r_grant_id, w_grant_id_nxt;
    logic [IDW-1:0] r_last_id, w_last_id_nxt;
    logic [IDW-1:0] r_fifo [MAX_PENDING];
    logic [PW:0]    r_wr_ptr, r_rd_ptr;
    logic           r_err;

    logic [NUM_MASTERS-1:0] w_req;
    logic [ADDR_WIDTH-1:0]  w_addr  [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  w_wdata [NUM_MASTERS];
    logic                   w_g_read, w_g_write;
    logic [IDW-1:0]         w_pick, w_idx;
    logic                   w_pick_found;
    logic                   w_fifo_empty, w_fifo_full, w_push, w_pop;
    logic                   w_accept, w_err_set;

    assign w_req = m_read_i | m_write_i;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_addr[i]  = m_address_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_wdata[i] = m_writedata_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign w_g_read  = m_read_i[r_grant_id];
    assign w_g_write = m_write_i[r_grant_id];

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                          (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_pop        = mem_readdatavalid_i & ~w_fifo_empty;
    assign w_push       = w_accept & mem_read_o;

    // Search last_id+1, last_id+2, ... wrapping; k == NUM_MASTERS revisits last_id itself.
    always_comb begin
        w_pick       = '0;
        w_idx        = '0;
        w_pick_found = 1'b0;
`ifdef MEM_ARB_PRIORITY0_EN
        if (w_req[0]) begin
            w_pick_found = 1'b1;
        end
`endif
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            w_idx = r_last_id + IDW'(k);
`ifdef MEM_ARB_PRIORITY0_EN
            if (!w_pick_found && (w_idx != '0) && w_req[w_idx]) begin
`else
            if (!w_pick_found && w_req[w_idx]) begin
`endif
                w_pick       = w_idx;
                w_pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        w_state_nxt     = r_state;
        w_grant_id_nxt  = r_grant_id;
        w_last_id_nxt   = r_last_id;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        mem_address_o   = '0;
        mem_writedata_o = '0;
        w_accept        = 1'b0;
        w_err_set       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt    = S_GRANT;
                    w_grant_id_nxt = w_pick;
                end
            end
            S_GRANT: begin
                // A read with no FIFO slot is held; a same-cycle pop frees one.
                mem_write_o     = w_g_write;
                mem_read_o      = w_g_read & ~w_g_write & ~(w_fifo_full & ~w_pop);
                mem_address_o   = {r_grant_id, w_addr[r_grant_id]};
                mem_writedata_o = w_wdata[r_grant_id];
                w_accept        = (mem_read_o | mem_write_o) & ~mem_waitrequest_i;
                w_err_set       = w_g_read & w_g_write;
                if (!w_g_read && !w_g_write) begin
                    w_state_nxt = S_IDLE;
                end else if (w_accept) begin
                    w_state_nxt = S_IDLE;
`ifdef MEM_ARB_PRIORITY0_EN
                    if (r_grant_id != '0) begin
                        w_last_id_nxt = r_grant_id;
                    end
`else
                    w_last_id_nxt = r_grant_id;
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_waitrequest_o[i] = !((r_state == S_GRANT) && (r_grant_id == IDW'(i)) && w_accept);
        end
    end

    always_comb begin
        m_readdatavalid_o = '0;
        if (w_pop) begin
            m_readdatavalid_o[r_fifo[r_rd_ptr[PW-1:0]]] = 1'b1;
        end
    end

    assign m_readdata_o = mem_readdata_i;
    assign err_o        = r_err;

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state    <= S_IDLE;
            r_grant_id <= '0;
            r_last_id  <= IDW'(NUM_MASTERS - 1);
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_last_id  <= w_last_id_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_err_set || (mem_readdatavalid_i && w_fifo_empty)) begin
                r_err <= 1'b1;
            end
        end
    end

    // NOTE: ID storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[PW-1:0]] <= r_grant_id;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: master command model, latency memory model and
// an in-order read-return scoreboard.

module tb_mem_arbiter;
    localparam int NM = 16, AW = 16, DW = 24, MP = 8, IDW = 4;

    logic              clk_i = 1'b0;
    logic              srst_i;
    logic [NM-1:0]     m_read_i, m_write_i;
    logic [NM*AW-1:0]  m_address_i;
    logic [NM*DW-1:0]  m_writedata_i;
    logic [NM-1:0]     m_waitrequest_o, m_readdatavalid_o;
    logic [DW-1:0]     m_readdata_o;
    logic              mem_read_o, mem_write_o;
    logic [AW+IDW-1:0] mem_address_o;
    logic [DW-1:0]     mem_writedata_o;
    logic              mem_waitrequest_i;
    logic [DW-1:0]     mem_readdata_i;
    logic              mem_readdatavalid_i;
    logic              err_o;

    mem_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_PENDING(MP)) dut (
        .clk_i(clk_i), .srst_i(srst_i),
        .m_read_i(m_read_i), .m_write_i(m_write_i),
        .m_address_i(m_address_i), .m_writedata_i(m_writedata_i),
        .m_waitrequest_o(m_waitrequest_o), .m_readdata_o(m_readdata_o),
        .m_readdatavalid_o(m_readdatavalid_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_address_o(mem_address_o), .mem_writedata_o(mem_writedata_o),
        .mem_waitrequest_i(mem_waitrequest_i), .mem_readdata_i(mem_readdata_i),
        .mem_readdatavalid_i(mem_readdatavalid_i), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; } cmd_t;
    typedef struct { int id; logic [DW-1:0] data; } exp_t;
    typedef struct { logic [DW-1:0] data; int due; } ret_t;

    cmd_t          cq [NM][$];
    cmd_t          cur [NM];
    bit            active [NM];
    bit            acc [NM];
    bit            gap [NM];
    exp_t          sb [$];
    ret_t          pipe [$];
    logic [DW-1:0] model_mem [int];
    logic [DW-1:0] ref_mem [int];
    int            grant_log [$];
    logic [NM-1:0] ret_log [$];
    int            cyc = 0, lat = 6;
    bit            inject = 1'b0;
    int            rd_out = 0, rd_accepts = 0, nine_cycle = -1, first_ret_cycle = -1, wr_cycle = -1;
    bit            rd_over = 1'b0;
    int            n_checks = 0, n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int key(input int m, input logic [AW-1:0] addr);
        return (m << AW) | int'(addr);
    endfunction

    function automatic logic [DW-1:0] ref_rd(input int k);
        return ref_mem.exists(k) ? ref_mem[k] : '0;
    endfunction

    function automatic logic [DW-1:0] model_rd(input int k);
        return model_mem.exists(k) ? model_mem[k] : '0;
    endfunction

    task automatic preload(input int m, input logic [AW-1:0] addr);
        logic [DW-1:0] d;
        d = DW'($urandom);
        ref_mem[key(m, addr)]   = d;
        model_mem[key(m, addr)] = d;
    endtask

    // Negedge: observe accepts and returns, feed the memory model.
    task automatic sample();
        exp_t e;
        if (m_readdatavalid_o != '0) begin
            ret_log.push_back(m_readdatavalid_o);
            if (first_ret_cycle < 0) first_ret_cycle = cyc;
            if (sb.size() == 0) begin
                check("rdv_unexpected", 64'(m_readdatavalid_o), 64'(0));
            end else begin
                e = sb.pop_front();
                rd_out--;
                check("rdv_id", 64'(m_readdatavalid_o), 64'(1) << e.id);
                check("rdv_data", 64'(m_readdata_o), 64'(e.data));
            end
        end
        for (int m = 0; m < NM; m++) begin
            if (!m_waitrequest_o[m]) begin
                if (!active[m] || acc[m]) begin
                    check("waitreq_spurious", 64'(m_waitrequest_o[m]), 64'(1));
                end else begin
                    acc[m] = 1'b1;
                    grant_log.push_back(m);
                    check("cmd_write", 64'(mem_write_o), 64'(cur[m].wr));
                    check("cmd_read", 64'(mem_read_o), 64'(!cur[m].wr));
                    check("cmd_addr", 64'(mem_address_o), 64'({IDW'(m), cur[m].addr}));
                    if (cur[m].wr) begin
                        check("cmd_wdata", 64'(mem_writedata_o), 64'(cur[m].data));
                        ref_mem[key(m, cur[m].addr)] = cur[m].data;
                        wr_cycle = cyc;
                    end else begin
                        sb.push_back('{m, ref_rd(key(m, cur[m].addr))});
                        rd_accepts++;
                        if (rd_accepts == 9) nine_cycle = cyc;
                        if (rd_out >= MP) rd_over = 1'b1;
                        rd_out++;
                    end
                end
            end
        end
        if (!mem_waitrequest_i) begin
            if (mem_write_o) model_mem[int'(mem_address_o)] = mem_writedata_o;
            if (mem_read_o) pipe.push_back('{model_rd(int'(mem_address_o)), cyc + lat});
        end
    endtask

    // Just after posedge: memory returns and master request lines.
    task automatic drive();
        ret_t r;
        cyc++;
        if (pipe.size() > 0 && pipe[0].due <= cyc) begin
            r = pipe.pop_front();
            mem_readdatavalid_i = 1'b1;
            mem_readdata_i      = r.data;
        end else begin
            mem_readdatavalid_i = inject;
            mem_readdata_i      = DW'($urandom);
        end
        for (int m = 0; m < NM; m++) begin
            if (acc[m]) begin
                acc[m]    = 1'b0;
                active[m] = 1'b0;
                gap[m]    = 1'b1;
            end else if (gap[m]) begin
                gap[m] = 1'b0;
            end else if (!active[m] && cq[m].size() > 0) begin
                cur[m]    = cq[m].pop_front();
                active[m] = 1'b1;
            end
            m_read_i[m]                = active[m] && !cur[m].wr;
            m_write_i[m]               = active[m] && cur[m].wr;
            m_address_i[m*AW +: AW]    = cur[m].addr;
            m_writedata_i[m*DW +: DW]  = cur[m].data;
        end
    endtask

    initial begin
        m_read_i = '0; m_write_i = '0; m_address_i = '0; m_writedata_i = '0;
        mem_readdatavalid_i = 1'b0; mem_readdata_i = '0;
        forever begin
            @(negedge clk_i);
            if (!srst_i) sample();
            @(posedge clk_i);
            #1;
            drive();
        end
    end

    function automatic bit bench_idle();
        if (sb.size() != 0 || pipe.size() != 0) return 1'b0;
        for (int m = 0; m < NM; m++) begin
            if (cq[m].size() != 0 || active[m] || acc[m] || gap[m]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_i);
            if (bench_idle()) begin
                repeat (2) @(negedge clk_i);
                return;
            end
        end
        check("timeout_idle", 64'(0), 64'(1));
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        srst_i = 1'b1;
        for (int m = 0; m < NM; m++) begin
            cq[m].delete();
            active[m] = 1'b0; acc[m] = 1'b0; gap[m] = 1'b0;
        end
        sb.delete(); pipe.delete();
        rd_out = 0;
        repeat (3) @(negedge clk_i);
        srst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_waitreq"}, 64'(m_waitrequest_o), 64'({NM{1'b1}}));
        check({tag, "_mem_rd"}, 64'(mem_read_o), 64'(0));
        check({tag, "_mem_wr"}, 64'(mem_write_o), 64'(0));
        check({tag, "_rdv"}, 64'(m_readdatavalid_o), 64'(0));
        check({tag, "_err"}, 64'(err_o), 64'(0));
    endtask

    int fair_exp [6];

    initial begin
        bit seen;
        srst_i = 1'b1;
        mem_waitrequest_i = 1'b0;
`ifdef MEM_ARB_PRIORITY0_EN
        fair_exp = '{0, 5, 0, 15, 0, 5};
`else
        fair_exp = '{0, 5, 15, 0, 5, 15};
`endif
        apply_reset();
        check_reset_state("reset");

        // Single master write: IDLE cycle t, accept at t+1, one-cycle waitrequest low.
        @(negedge clk_i);
        cq[3].push_back('{1'b1, 16'h0012, 24'hABCDEF});
        @(negedge clk_i);
        check("single_idle_wr", 64'(mem_write_o), 64'(0));
        check("single_idle_wait", 64'(m_waitrequest_o[3]), 64'(1));
        @(negedge clk_i);
        check("single_wr", 64'(mem_write_o), 64'(1));
        check("single_addr", 64'(mem_address_o), 64'(20'h30012));
        check("single_data", 64'(mem_writedata_o), 64'(24'hABCDEF));
        check("single_wait_low", 64'(m_waitrequest_o[3]), 64'(0));
        @(negedge clk_i);
        check("single_wait_high", 64'(m_waitrequest_o[3]), 64'(1));
        wait_idle(50);

        // Fairness from a fresh reset (last_id = NM-1).
        apply_reset();
        grant_log.delete();
        for (int j = 0; j < 3; j++) begin
            cq[0].push_back('{1'b1, AW'(16'h0100 + j), DW'($urandom)});
            cq[5].push_back('{1'b1, AW'(16'h0200 + j), DW'($urandom)});
            cq[15].push_back('{1'b1, AW'(16'h0300 + j), DW'($urandom)});
        end
        wait_idle(200);
        check("fair_count", 64'(grant_log.size()), 64'(9));
        if (grant_log.size() >= 6) begin
            for (int i = 0; i < 6; i++) check($sformatf("fair_%0d", i), 64'(grant_log[i]), 64'(fair_exp[i]));
        end

        // Stall: waitrequest high for 4 grant cycles, accept in the 5th.
        @(negedge clk_i);
        mem_waitrequest_i = 1'b1;
        cq[7].push_back('{1'b1, 16'h0BEE, 24'h123456});
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk_i);
            seen = mem_write_o;
        end
        check("stall_granted", 64'(seen), 64'(1));
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clk_i);
            check("stall_addr", 64'(mem_address_o), 64'(20'h70BEE));
            check("stall_held", 64'(m_waitrequest_o[7]), 64'(1));
        end
        @(posedge clk_i);
        #1;
        mem_waitrequest_i = 1'b0;
        @(negedge clk_i);
        check("stall_accept", 64'(m_waitrequest_o[7]), 64'(0));
        wait_idle(50);

        // Read ordering with latency 6.
        lat = 6;
        preload(1, 16'h0040); preload(2, 16'h0041); preload(1, 16'h0042);
        ret_log.delete();
        @(negedge clk_i);
        cq[1].push_back('{1'b0, 16'h0040, '0});
        cq[2].push_back('{1'b0, 16'h0041, '0});
        cq[1].push_back('{1'b0, 16'h0042, '0});
        wait_idle(200);
        check("order_count", 64'(ret_log.size()), 64'(3));
        if (ret_log.size() == 3) begin
            check("order_0", 64'(ret_log[0]), 64'(16'h0002));
            check("order_1", 64'(ret_log[1]), 64'(16'h0004));
            check("order_2", 64'(ret_log[2]), 64'(16'h0002));
        end

        // FIFO full: nine reads outstanding attempted, one write interleaved.
        lat = 40;
        rd_accepts = 0; nine_cycle = -1; first_ret_cycle = -1; wr_cycle = -1; rd_over = 1'b0;
        for (int m = 1; m <= 8; m++) preload(m, AW'(16'h0100 + m));
        preload(1, 16'h0200);
        @(negedge clk_i);
        for (int m = 1; m <= 8; m++) cq[m].push_back('{1'b0, AW'(16'h0100 + m), '0});
        cq[1].push_back('{1'b0, 16'h0200, '0});
        cq[9].push_back('{1'b1, 16'h0300, 24'h5A5A5A});
        wait_idle(400);
        check("full_reads", 64'(rd_accepts), 64'(9));
        check("full_no_overflow", 64'(rd_over), 64'(0));
        check("full_ninth_at_return", 64'(nine_cycle), 64'(first_ret_cycle));
        check("full_write_first", 64'(wr_cycle >= 0 && wr_cycle < first_ret_cycle), 64'(1));
        lat = 6;

        // Stray return with empty FIFO, then reset clears the error.
        check("err_clean", 64'(err_o), 64'(0));
        @(negedge clk_i);
        inject = 1'b1;
        @(negedge clk_i);
        inject = 1'b0;
        check("stray_no_rdv", 64'(m_readdatavalid_o), 64'(0));
        @(negedge clk_i);
        check("stray_err", 64'(err_o), 64'(1));
        apply_reset();
        check_reset_state("rst2");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
